// File: rtl/secure_keystore_pkg.sv
// Shared types and constants for the on-chip key store: op codes, FSM encoding and
// the default key image loaded into the storage array at elaboration.
package secure_keystore_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_LOCK    = 2'd2,
    OP_ZEROIZE = 2'd3
  } keystore_op_e;

  // FSM encoding: IDLE accepts requests, ZERO runs the clearing sweep.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ZERO = 1'b1;

  localparam int unsigned MAX_DEPTH = 8;

  // Default keys; entries are truncated to the instance WIDTH.
  localparam logic [255:0] KEYSTORE_INIT [MAX_DEPTH] = '{
    {8{32'hC0DE_0000}},
    {8{32'hC0DE_0001}},
    {8{32'hC0DE_0002}},
    {8{32'hC0DE_0003}},
    {8{32'hC0DE_0004}},
    {8{32'hC0DE_0005}},
    {8{32'hC0DE_0006}},
    {8{32'hC0DE_0007}}
  };

endpackage

// File: rtl/secure_keystore_array.sv
// Key storage: WIDTH x DEPTH entries, one synchronous write port and a registered read
// port whose output returns to zero whenever no read is requested.
module secure_keystore_array
  import secure_keystore_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 6,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = KEYSTORE_INIT[i][WIDTH-1:0];
    end
    return m;
  endfunction

  // Contents are fixed at elaboration and deliberately untouched by reset.
  mem_t mem = init_mem();

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= re ? mem[raddr] : '0;
  end

endmodule

// File: rtl/secure_keystore.sv
// Key store top level: request register, FSM, sticky lock bits, zeroize sweep counter and
// single-cycle response generation around the storage array.
module secure_keystore
  import secure_keystore_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 6,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [DEPTH-1:0] lock_status
);

  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] lock_q, lock_d;

  logic             req_vld_q;
  keystore_op_e     req_op_q;
  logic [AW-1:0]    req_addr_q;
  logic [WIDTH-1:0] req_wdata_q;

  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_rd_q, rsp_rd_d;

  logic             accept, in_range, locked;
  logic             arr_we, arr_re;
  logic [AW-1:0]    arr_waddr;
  logic [WIDTH-1:0] arr_wdata, arr_rdata;

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_ZERO);
  assign accept      = req_valid & req_ready;
  assign in_range    = ({1'b0, req_addr_q} < DEPTH_X);
  assign locked      = in_range & lock_q[req_addr_q];
  assign lock_status = lock_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  // Only a successful READ may put key material on the response bus.
  assign rsp_data    = rsp_rd_q ? arr_rdata : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_d      = lock_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rd_d    = 1'b0;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_waddr   = req_addr_q;
    arr_wdata   = req_wdata_q;

    // Registered request stage; ZEROIZE answers only when its sweep completes.
    if (req_vld_q && req_op_q != OP_ZEROIZE) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range || (req_op_q == OP_WRITE && locked);
      if (!rsp_err_d) begin
        case (req_op_q)
          OP_READ: begin
            arr_re   = 1'b1;
            rsp_rd_d = 1'b1;
          end
          OP_WRITE: arr_we = 1'b1;
          OP_LOCK:  lock_d[req_addr_q] = 1'b1;
          default:  ;
        endcase
      end
    end

    if (busy) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wdata = '0;
      if (cnt_q == LAST) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        lock_d      = '0;
        rsp_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (accept && req_op == OP_ZEROIZE) begin
      state_d = ST_ZERO;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lock_q      <= '0;
      req_vld_q   <= 1'b0;
      req_op_q    <= OP_READ;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      req_vld_q   <= accept;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
      if (accept) begin
        req_op_q    <= keystore_op_e'(req_op);
        req_addr_q  <= req_addr;
        req_wdata_q <= req_wdata;
      end
    end
  end

  secure_keystore_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_addr_q),
    .rdata (arr_rdata)
  );

endmodule
